// File: rtl/quad_step_decoder_if.sv
// Quadrature decoder signal bundle: phase inputs and error clear in, step/direction/error out.
interface quad_step_decoder_if;
  logic chan_a;
  logic chan_b;
  logic clr_err;
  logic en;
  logic ctrl;
  logic err;

  modport master (
    output chan_a,
    output chan_b,
    output clr_err,
    input  en,
    input  ctrl,
    input  err
  );

  modport slave (
    input  chan_a,
    input  chan_b,
    input  clr_err,
    output en,
    output ctrl,
    output err
  );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature front end: synchronises and glitch-filters channels A/B, decodes Gray-code steps
// into a one-cycle step enable plus direction, and flags double transitions with a sticky error.
module quad_step_decoder #(
  parameter int unsigned FILT_CYCLES = 4,
  parameter bit          DIR_UP_AB   = 1'b1
) (
  input logic           clk,
  input logic           reset,
  quad_step_decoder_if.slave bus
);

  localparam logic [3:0] FiltLast = 4'(FILT_CYCLES - 1);

  // Bit 1 carries channel A, bit 0 carries channel B throughout.
  logic [1:0] s1_q, s2_q;
  logic [1:0] filt_q, filt_d;
  logic [1:0] prev_q;
  logic [3:0] cnt_q [2];
  logic [3:0] cnt_d [2];
  logic       en_q, en_d;
  logic       ctrl_q, ctrl_d;
  logic       err_q, err_d;
  logic [1:0] delta;
  logic       fwd;

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == FiltLast) begin
          filt_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // A-leads-B order is 00->10->11->01->00; new A differing from old B marks that order.
  assign delta = filt_q ^ prev_q;
  assign fwd   = filt_q[1] ^ prev_q[0];

  always_comb begin
    en_d   = 1'b0;
    ctrl_d = ctrl_q;
    err_d  = bus.clr_err ? 1'b0 : err_q;
    case (delta)
      2'b00: ;
      2'b11: err_d = 1'b1;
      default: begin
        en_d   = 1'b1;
        ctrl_d = fwd ? DIR_UP_AB : ~DIR_UP_AB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      filt_q   <= '0;
      prev_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      en_q     <= 1'b0;
      ctrl_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s1_q     <= {bus.chan_a, bus.chan_b};
      s2_q     <= s1_q;
      filt_q   <= filt_d;
      prev_q   <= filt_q;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      en_q     <= en_d;
      ctrl_q   <= ctrl_d;
      err_q    <= err_d;
    end
  end

  assign bus.en   = en_q;
  assign bus.ctrl = ctrl_q;
  assign bus.err  = err_q;

endmodule
